// File: rtl/mult_div_ctrl.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) engine owning HI/LO.
// Define MDU_ZERO_SKIP_EN to let a MULT with a zero operand bypass the iterations.
module mult_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t           state_q;
  logic [5:0]       cnt_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] mq_q;
  logic [WIDTH-1:0] mcand_q;
  logic             q1_q;
  logic             op_div_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             busy_q;
  logic             done_q;
  logic             div_zero_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH:0]   mcand_ext_s;
  logic [WIDTH:0]   booth_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH:0]   div_diff_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] abs_a_s;
  logic [WIDTH-1:0] abs_b_s;
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] rem_fix_s;
  logic             last_iter_s;
  logic             zero_skip_s;

`ifdef MDU_ZERO_SKIP_EN
  assign zero_skip_s = (a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}});
`else
  assign zero_skip_s = 1'b0;
`endif

  // Datapath helpers: Booth add/sub step, restoring-division trial subtract, sign fixups.
  always_comb begin
    mcand_ext_s = {mcand_q[WIDTH-1], mcand_q};
    case ({mq_q[0], q1_q})
      2'b01:   booth_sum_s = acc_q + mcand_ext_s;
      2'b10:   booth_sum_s = acc_q - mcand_ext_s;
      default: booth_sum_s = acc_q;
    endcase
    div_shift_s = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, mcand_q};
    div_ge_s    = (div_shift_s >= {1'b0, mcand_q});
    abs_a_s     = a[WIDTH-1] ? -a : a;
    abs_b_s     = b[WIDTH-1] ? -b : b;
    quo_fix_s   = neg_quo_q ? -mq_q : mq_q;
    rem_fix_s   = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    last_iter_s = (cnt_q == 6'(WIDTH-1));
  end

  // Sequencer, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      acc_q      <= {(WIDTH+1){1'b0}};
      mq_q       <= {WIDTH{1'b0}};
      mcand_q    <= {WIDTH{1'b0}};
      q1_q       <= 1'b0;
      op_div_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= 6'd0;
          if (start_mult) begin
            mcand_q  <= a;
            acc_q    <= {(WIDTH+1){1'b0}};
            q1_q     <= 1'b0;
            op_div_q <= 1'b0;
            busy_q   <= 1'b1;
            if (zero_skip_s) begin
              mq_q    <= {WIDTH{1'b0}};
              state_q <= S_FIN;
            end else begin
              mq_q    <= b;
              state_q <= S_MUL;
            end
          end else if (start_div) begin
            if (b == {WIDTH{1'b0}}) begin
              div_zero_q <= 1'b1;
            end else begin
              mcand_q   <= abs_b_s;
              mq_q      <= abs_a_s;
              acc_q     <= {(WIDTH+1){1'b0}};
              neg_quo_q <= a[WIDTH-1] ^ b[WIDTH-1];
              neg_rem_q <= a[WIDTH-1];
              op_div_q  <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= S_DIV;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_MUL: begin
          // Arithmetic shift of {acc, multiplier, q-1} after the Booth step.
          acc_q <= {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
          mq_q  <= {booth_sum_s[0], mq_q[WIDTH-1:1]};
          q1_q  <= mq_q[0];
          cnt_q <= last_iter_s ? 6'd0 : cnt_q + 6'd1;
          if (last_iter_s) begin
            state_q <= S_FIN;
          end else begin
            state_q <= S_MUL;
          end
        end
        S_DIV: begin
          acc_q <= div_ge_s ? div_diff_s : div_shift_s;
          mq_q  <= {mq_q[WIDTH-2:0], div_ge_s};
          cnt_q <= last_iter_s ? 6'd0 : cnt_q + 6'd1;
          if (last_iter_s) begin
            state_q <= S_FIN;
          end else begin
            state_q <= S_DIV;
          end
        end
        S_FIN: begin
          if (op_div_q) begin
            hi_q <= rem_fix_s;
            lo_q <= quo_fix_s;
          end else begin
            hi_q <= acc_q[WIDTH-1:0];
            lo_q <= mq_q;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= 6'd0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          cnt_q   <= 6'd0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: doc/mult_div_ctrl.md
# mult_div_ctrl

Iterative signed multiply/divide engine with its own sequencer. It owns the HI/LO registers and serves MULT, DIV, MFHI and MFLO. The main control unit issues a one-cycle start pulse with the A/B register operands, then waits for `done` (or `div_zero`) before continuing the instruction. `div_zero` feeds the zero-division exception path.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI/LO are `WIDTH` each.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start_mult`  in  1  one-cycle pulse: begin signed A×B.
- `start_div`  in  1  one-cycle pulse: begin signed A÷B.
- `a`  in  WIDTH  operand A (rs); sampled only on an accepted start.
- `b`  in  WIDTH  operand B (rt); sampled only on an accepted start.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse: HI/LO hold the new result.
- `div_zero`  out  1  one-cycle pulse: DIV with `b`==0 was rejected.
- `hi`  out  WIDTH  HI register (product high word / remainder).
- `lo`  out  WIDTH  LO register (product low word / quotient).

## Operation
- States:
  - IDLE: waiting for a start.
  - MUL: radix-2 Booth, one iteration per cycle.
  - DIV: restoring division on operand magnitudes, one iteration per cycle.
  - FIN: sign fixup and HI/LO write.
- A 6-bit iteration counter counts 0..WIDTH-1.
- Start acceptance:
  - A start is accepted only in IDLE. Starts while `busy` are ignored and not queued.
  - If `start_mult` and `start_div` are both high, MULT wins and the divide is dropped.
- IDLE→MUL on `start_mult`: latch `a`, `b`; clear the accumulator and counter.
- IDLE→DIV on `start_div` with `b`≠0: latch \|a\|, \|b\|, and the sign of a and of b.
- DIV with `b`==0: stay in IDLE, pulse `div_zero`, leave HI/LO untouched, keep `busy` low, never assert `done`.
- MUL/DIV→FIN after iteration WIDTH-1. FIN→IDLE unconditionally.
- MULT result: the full 2·WIDTH signed product; HI = upper word, LO = lower word.
- DIV result:
  - Quotient truncates toward zero; it is negated when sign(a)≠sign(b).
  - Remainder takes the sign of the dividend.
  - Quotient → LO, remainder → HI.
  - Overflow case −2^31 ÷ −1: LO = 0x80000000, HI = 0, no flag.
- HI/LO change only in FIN. They hold their value across every other state and across rejected or ignored starts.
- Reset low at any edge, including mid-operation:
  - state = IDLE, counter = 0.
  - hi = lo = 0.
  - busy = done = div_zero = 0.
  - The in-flight operation is discarded.

## Timing
- Let edge k be the edge that accepts the start.
- `busy`: high from after edge k until edge k+WIDTH+1.
- Edges k+1 .. k+WIDTH: iterations.
- Edge k+WIDTH+1 (FIN):
  - HI/LO are written.
  - `done` = 1 for exactly one cycle.
  - `busy` = 0 in that same cycle.
- Start-to-done: WIDTH+2 cycles (34 at WIDTH=32), identical for MULT and DIV.
- A new start may be accepted in the cycle where `done` is high.
- `div_zero`: high for the single cycle after edge k.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values of all outputs: 0.

## Configuration
- `MDU_ZERO_SKIP_EN`
  - Defined: a MULT accepted with `a`==0 or `b`==0 skips MUL and goes straight to FIN. HI = LO = 0, `done` pulses after edge k+1 (2-cycle latency), `busy` high for one cycle.
  - Undefined: every MULT takes the full WIDTH+2 cycles.
  - DIV timing is identical either way.

## Test plan
- MULT a=7, b=0xFFFFFFFD (−3) → `done` 34 cycles after start; HI=0xFFFFFFFF, LO=0xFFFFFFEB. Repeat with a=b=0x80000000 → HI=0x40000000, LO=0.
- DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- Preload HI/LO via a MULT, then DIV a=5, b=0 → `div_zero` high one cycle; `busy` and `done` stay 0; HI/LO unchanged.
- Arbitration: `start_mult` and `start_div` together with a=3, b=4 → LO=12, HI=0. A `start_div` pulse at cycle 10 of that MULT → ignored; exactly one `done`.
- Reset low at iteration 10 of DIV 100/7 → next cycle hi=lo=0, busy=0, no `done`. Re-issue DIV 100/7 → LO=14, HI=2 after 34 cycles.
- MULT a=0, b=123:
  - With `MDU_ZERO_SKIP_EN` defined: `done` after 2 cycles, HI=LO=0.
  - Without it: `done` after 34 cycles, same result.
